pri_req_latch: RTL and testbench

Upstream request-capture stage for the 16-to-4 priority encoder. Synchronises 16 asynchronous request lines, detects rising edges, and holds each event as a sticky pending bit until the consumer acknowledges that index. The 16-bit pending vector drives the encoder input directly. Lost events (re-assertion while still pending) are counted for debug.

---
 rtl/pri_pkg.sv | 25 ++
 rtl/pri_sync.sv | 34 +++
 rtl/pri_req_latch.sv | 107 ++++++++++
 tb/tb_pri_req_latch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pri_pkg.sv
// Shared definitions for the request-capture stage and the 16-to-4 priority
// encoder that consumes its pending vector.
//
// Contents:
//   WIDTH          default number of request lines / encoder inputs
//   IDX_W          width of an index into the request vector
//   PRI_NONE_CODE  encoder output when no request is pending
//   idx_hits()     true when an index addresses a given bit and is in range
package pri_pkg;

    localparam int WIDTH = 16;
    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [7:0] PRI_NONE_CODE = 8'hF0;

    // An index at or beyond the vector width addresses nothing.
    function automatic bit idx_hits(
        input int unsigned idx,
        input int unsigned bit_pos,
        input int unsigned width
    );
        return (idx < width) && (idx == bit_pos);
    endfunction

endpackage

// File: rtl/pri_sync.sv
// Single-bit synchroniser for one asynchronous request line.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset, clears every stage
//   d_in   asynchronous input
//   s_out  synchronised output, SYNC_STAGES edges behind d_in
module pri_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic s_out
);

    logic [SYNC_STAGES-1:0] stg_q;
    logic [SYNC_STAGES-1:0] stg_d;

    always_comb begin
        stg_d = {stg_q[SYNC_STAGES-2:0], d_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

    assign s_out = stg_q[SYNC_STAGES-1];

endmodule

// File: rtl/pri_req_latch.sv
// Request-capture stage in front of the priority encoder. Each request line is
// synchronised, rising edges are detected, and every event is held as a sticky
// pending bit until the consumer acknowledges that index. Re-assertion of a
// line whose bit is still pending is a lost event and is counted.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   req_in     asynchronous request lines, a rising edge is one event
//   mask_in    per-line capture enable (1 = capture)
//   ack_valid  consumer serviced ack_idx this cycle
//   ack_idx    index being acknowledged, out-of-range values are ignored
//   clr_drop   zero the dropped-event counter
//   pend_out   registered pending vector, feeds the encoder
//   pend_any   registered OR of the pending vector
//   drop_cnt   saturating count of cycles with at least one dropped event
module pri_req_latch #(
    parameter int WIDTH       = pri_pkg::WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    localparam int ACK_IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req_in,
    input  logic [WIDTH-1:0]     mask_in,
    input  logic                 ack_valid,
    input  logic [ACK_IDX_W-1:0] ack_idx,
    input  logic                 clr_drop,
    output logic [WIDTH-1:0]     pend_out,
    output logic                 pend_any,
    output logic [CNT_W-1:0]     drop_cnt
);

    import pri_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] s_sync;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] pend_d;
    logic             pend_any_q;
    logic             pend_any_d;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr_hit;
    logic [WIDTH-1:0] drop_vec;
    logic [CNT_W-1:0] cnt_base;

    for (genvar g = 0; g < WIDTH; g++) begin : g_sync
        pri_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst   (rst),
            .d_in  (req_in[g]),
            .s_out (s_sync[g])
        );
    end

    always_comb begin
        prev_d  = s_sync;
        rise    = s_sync & ~prev_q & mask_in;

        clr_hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            clr_hit[i] = ack_valid & idx_hits(32'(ack_idx), i, WIDTH);
        end

        // A set and a clear on the same bit is a fresh event after service:
        // the set wins and it is not a drop.
        drop_vec   = rise & pend_q & ~clr_hit;
        pend_d     = rise | (pend_q & ~clr_hit);
        pend_any_d = |pend_d;

        // Clear first, then count, so a drop coinciding with clr_drop gives 1.
        cnt_base   = clr_drop ? '0 : drop_cnt_q;
        drop_cnt_d = cnt_base;
        if ((|drop_vec) && (cnt_base != '1)) begin
            drop_cnt_d = cnt_base + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            pend_q     <= '0;
            pend_any_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            prev_q     <= prev_d;
            pend_q     <= pend_d;
            pend_any_q <= pend_any_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pend_out = pend_q;
    assign pend_any = pend_any_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pri_req_latch.sv
module tb_pri_req_latch;

    localparam int W = 16;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  req_in;
    logic [W-1:0]  mask_in;
    logic          ack_valid;
    logic [3:0]    ack_idx;
    logic          clr_drop;
    logic [W-1:0]  pend_out;
    logic          pend_any;
    logic [7:0]    drop_cnt;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    pri_req_latch #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .mask_in   (mask_in),
        .ack_valid (ack_valid),
        .ack_idx   (ack_idx),
        .clr_drop  (clr_drop),
        .pend_out  (pend_out),
        .pend_any  (pend_any),
        .drop_cnt  (drop_cnt)
    );

    // Reference model: hist[k] is the request vector sampled k+1 edges ago.
    // A line is seen as synchronised S edges after it is sampled; an event is
    // a line seen high now that was seen low one edge earlier.
    logic [W-1:0] hist [0:S];
    logic [W-1:0] m_pend = '0;
    bit           m_any  = 1'b0;
    int           m_cnt  = 0;

    always @(posedge clk) begin
        logic [W-1:0] seen_now, seen_prev, ev;
        bit any_drop;
        if (rst) begin
            for (int k = 0; k <= S; k++) hist[k] = '0;
            m_pend = '0;
            m_cnt  = 0;
        end else begin
            seen_now  = hist[S-1];
            seen_prev = hist[S];
            ev        = seen_now & ~seen_prev & mask_in;
            any_drop  = 1'b0;
            for (int i = 0; i < W; i++) begin
                bit acked;
                acked = ack_valid && (int'(ack_idx) == i);
                if (ev[i]) begin
                    if (m_pend[i] && !acked) any_drop = 1'b1;
                    m_pend[i] = 1'b1;
                end else if (acked) begin
                    m_pend[i] = 1'b0;
                end
            end
            if (clr_drop) m_cnt = 0;
            if (any_drop && m_cnt < 255) m_cnt = m_cnt + 1;
            for (int k = S; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = req_in;
        end
        m_any = (m_pend != '0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (pend_out !== m_pend) begin
                n_err++;
                $display("FAIL model_pend t=%0t dut=%h model=%h", $time, pend_out, m_pend);
            end
            n_checks++;
            if (pend_any !== m_any) begin
                n_err++;
                $display("FAIL model_any t=%0t dut=%b model=%b", $time, pend_any, m_any);
            end
            n_checks++;
            if (drop_cnt !== 8'(m_cnt)) begin
                n_err++;
                $display("FAIL model_drop t=%0t dut=%0d model=%0d", $time, drop_cnt, m_cnt);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [W-1:0] m);
        req_in = req_in | m;
        tick(2);
        req_in = req_in & ~m;
        tick(2);
    endtask

    task automatic do_ack(input int idx);
        ack_valid = 1'b1;
        ack_idx   = 4'(idx);
        tick(1);
        ack_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_in    = 16'hFFFF;
        mask_in   = 16'hFFFF;
        ack_valid = 1'b0;
        ack_idx   = '0;
        clr_drop  = 1'b0;

        // Reset held three edges with all requests high.
        tick(1);
        chk_en = 1'b1;
        chk("rst_pend0", 32'(pend_out), 32'h0);
        chk("rst_drop0", 32'(drop_cnt), 32'h0);
        tick(1);
        chk("rst_pend1", 32'(pend_out), 32'h0);
        tick(1);
        chk("rst_pend2", 32'(pend_out), 32'h0);
        chk("rst_any2",  32'(pend_any), 32'h0);
        rst = 1'b0;
        tick(1);
        chk("rel_pend_e1", 32'(pend_out), 32'h0);
        tick(2);
        chk("rel_pend_full", 32'(pend_out), 32'hFFFF);
        chk("rel_any", 32'(pend_any), 32'h1);

        rst = 1'b1;
        req_in = '0;
        tick(1);
        rst = 1'b0;
        tick(3);

        // Single event and ack.
        req_in = 16'h0020;
        tick(2);
        chk("single_not_yet", 32'(pend_out), 32'h0);
        tick(1);
        chk("single_pend", 32'(pend_out), 32'h0020);
        chk("single_any", 32'(pend_any), 32'h1);
        tick(1);
        do_ack(5);
        chk("ack_pend", 32'(pend_out), 32'h0);
        chk("ack_any", 32'(pend_any), 32'h0);
        req_in = '0;
        tick(3);

        // Drop and saturation.
        pulse(16'h0008);
        pulse(16'h0008);
        tick(3);
        chk("drop_one", 32'(drop_cnt), 32'd1);
        chk("drop_pend", 32'(pend_out), 32'h0008);
        repeat (300) pulse(16'h0008);
        tick(3);
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        clr_drop = 1'b1;
        tick(1);
        clr_drop = 1'b0;
        chk("drop_clr", 32'(drop_cnt), 32'd0);
        do_ack(3);
        tick(1);

        // Set and ack on bit 7 in the same cycle.
        pulse(16'h0080);
        tick(2);
        chk("coll_pre", 32'(pend_out), 32'h0080);
        req_in = 16'h0080;
        tick(2);
        ack_valid = 1'b1;
        ack_idx   = 4'd7;
        tick(1);
        ack_valid = 1'b0;
        chk("coll_bit7", 32'(pend_out[7]), 32'h1);
        chk("coll_drop", 32'(drop_cnt), 32'd0);
        req_in = '0;
        tick(3);
        do_ack(7);
        chk("coll_cleared", 32'(pend_out), 32'h0);

        // Mask.
        mask_in = 16'hFF00;
        pulse(16'h00FF);
        tick(3);
        chk("mask_blocked", 32'(pend_out), 32'h0);
        mask_in = 16'hFFFF;
        pulse(16'h00FF);
        tick(3);
        chk("mask_open", 32'(pend_out), 32'h00FF);

        // Mid-operation reset with a concurrent ack.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        pulse(16'h8001);
        tick(2);
        chk("mid_pend", 32'(pend_out), 32'h8001);
        repeat (4) pulse(16'h0001);
        tick(3);
        chk("mid_drop", 32'(drop_cnt), 32'd4);
        rst = 1'b1;
        ack_valid = 1'b1;
        ack_idx = 4'd0;
        tick(1);
        chk("mid_rst_pend", 32'(pend_out), 32'h0);
        chk("mid_rst_any", 32'(pend_any), 32'h0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'h0);
        rst = 1'b0;
        ack_valid = 1'b0;
        tick(4);
        chk("mid_after", 32'(pend_out), 32'h0);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            req_in    = req_in ^ 16'($urandom & $urandom & $urandom);
            mask_in   = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'hFFFF;
            ack_valid = 1'($urandom_range(0, 1));
            ack_idx   = 4'($urandom_range(0, 15));
            clr_drop  = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0;
        ack_valid = 1'b0;
        clr_drop = 1'b0;
        tick(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
